modbus_frame_rx: RTL and testbench

Modbus RTU frame receiver sitting directly behind `uart_byte_rx` in the slave datapath. It does the following:
- consumes received bytes;
- delimits frames by RTU silent-interval timing (t1.5 / t3.5);
- runs CRC-16/Modbus on the fly and filters by slave address;
- stores the frame in an internal byte buffer.

It presents a validated frame to the request decoder through a level valid / pulse ack handshake and a synchronous buffer read port.

---
 rtl/modbus_frame_rx.sv | 219 +++++++++++++++++++++
 tb/tb_modbus_frame_rx.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modbus_frame_rx.sv
// ----------------------------------------------------------------------------
// modbus_frame_rx
// Modbus RTU frame receiver placed behind uart_byte_rx. Frames are delimited
// by line silence (t1.5 inter-character limit, t3.5 end of frame), checked
// with CRC-16/Modbus computed on the fly, filtered by station address and
// held in an internal byte buffer until the consumer acknowledges them.
//
// Ports:
//   clk_in       system clock
//   rst_n_in     asynchronous active-low reset
//   rx_data      received byte, valid while rx_done is high
//   rx_done      one-cycle byte-received strobe
//   rx_state     UART receiver busy (start bit through stop bit)
//   frame_valid  level: a good frame is held in the buffer
//   frame_ack    one-cycle pulse: consumer is finished with the buffer
//   frame_len    byte count of the held frame, CRC bytes included
//   frame_bcast  held frame was addressed to 0x00
//   frame_err    one-cycle pulse: a frame was discarded
//   err_type     {overflow or short, inter-char gap, CRC} of the last check
//   rd_addr      buffer read address
//   rd_data      registered buffer read data
//   busy         frame reception in progress
// ----------------------------------------------------------------------------
module modbus_frame_rx #(
    parameter int         CLK_FREQ   = 50000000,
    parameter int         BAUD_RATE  = 115200,
    parameter logic [7:0] SLAVE_ADDR = 8'h01,
    parameter int         MAX_LEN    = 256,
    localparam int        AW         = $clog2(MAX_LEN)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    input  logic          rx_state,
    output logic          frame_valid,
    input  logic          frame_ack,
    output logic [AW:0]   frame_len,
    output logic          frame_bcast,
    output logic          frame_err,
    output logic [2:0]    err_type,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          busy
);

    // Above 19200 baud Modbus fixes the silent intervals at 750 us / 1750 us;
    // below it they scale with the character time (11 bits per character).
    localparam longint CLK_L  = longint'(CLK_FREQ);
    localparam longint BAUD_L = longint'(BAUD_RATE);
    localparam longint T15_L  = (BAUD_RATE > 19200) ? (CLK_L * 750) / 1000000
                                                    : (CLK_L * 33) / (2 * BAUD_L);
    localparam longint T35_L  = (BAUD_RATE > 19200) ? (CLK_L * 1750) / 1000000
                                                    : (CLK_L * 77) / (2 * BAUD_L);
    localparam logic [31:0] T15 = 32'(T15_L);
    localparam logic [31:0] T35 = 32'(T35_L);

    localparam logic [AW:0] LEN_MAX = (AW+1)'(MAX_LEN);
    localparam logic [AW:0] LEN_MIN = (AW+1)'(4);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RECV,
        S_CHECK,
        S_PEND
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   sil;
    logic [15:0]   crc;
    logic [AW:0]   len;
    logic          gap_flag;
    logic          ovf_flag;
    logic [7:0]    addr_byte;
    logic [7:0]    mem [MAX_LEN];

    logic          start_frame;
    logic          accept_byte;
    logic          frame_good;
    logic          frame_bad;
    logic          frame_release;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [2:0]    err_vec;
    logic          addr_ok;

    // One byte of CRC-16/Modbus (reflected 0xA001), all eight shifts unrolled.
    function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    assign err_vec = {(len < LEN_MIN) || ovf_flag, gap_flag, crc != 16'h0000};
    assign addr_ok = (addr_byte == SLAVE_ADDR) || (addr_byte == 8'h00);
    assign busy    = (state == S_RECV);

    // Next-state logic and the one-cycle control strobes that drive the datapath.
    // A byte strobe in RECV wins over the end-of-frame silence test.
    always_comb begin
        state_next    = state;
        start_frame   = 1'b0;
        accept_byte   = 1'b0;
        frame_good    = 1'b0;
        frame_bad     = 1'b0;
        frame_release = 1'b0;
        case (state)
            S_INIT: begin
                if (sil >= T35) state_next = S_IDLE;
            end
            S_IDLE: begin
                if (rx_done) begin
                    start_frame = 1'b1;
                    state_next  = S_RECV;
                end
            end
            S_RECV: begin
                if (rx_done) begin
                    accept_byte = 1'b1;
                end else if (sil >= T35) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (err_vec != 3'b000) begin
                    frame_bad  = 1'b1;
                    state_next = S_INIT;
                end else if (addr_ok) begin
                    frame_good = 1'b1;
                    state_next = S_PEND;
                end else begin
                    state_next = S_INIT;
                end
            end
            S_PEND: begin
                if (frame_ack) begin
                    frame_release = 1'b1;
                    state_next    = S_INIT;
                end
            end
            default: state_next = S_INIT;
        endcase
    end

    assign wr_en   = start_frame || (accept_byte && (len < LEN_MAX));
    assign wr_addr = start_frame ? '0 : len[AW-1:0];

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= S_INIT;
        else           state <= state_next;
    end

    // Silence timer, CRC and per-frame bookkeeping.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sil       <= '0;
            crc       <= 16'hFFFF;
            len       <= '0;
            gap_flag  <= 1'b0;
            ovf_flag  <= 1'b0;
            addr_byte <= 8'h00;
        end else begin
            if (rx_state)        sil <= '0;
            else if (sil < T35)  sil <= sil + 32'd1;

            if (start_frame) begin
                crc       <= crc_fold(16'hFFFF, rx_data);
                len       <= (AW+1)'(1);
                gap_flag  <= 1'b0;
                ovf_flag  <= 1'b0;
                addr_byte <= rx_data;
            end else if (accept_byte) begin
                crc <= crc_fold(crc, rx_data);
                if (len < LEN_MAX) len <= len + (AW+1)'(1);
                else               ovf_flag <= 1'b1;
                if (sil >= T15)    gap_flag <= 1'b1;
            end
        end
    end

    // Consumer-facing status registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_type    <= 3'b000;
            frame_len   <= '0;
            frame_bcast <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            if (state == S_CHECK) err_type <= err_vec;
            if (frame_good) begin
                frame_valid <= 1'b1;
                frame_len   <= len;
                frame_bcast <= (addr_byte == 8'h00);
            end else if (frame_release) begin
                frame_valid <= 1'b0;
            end
        end
    end

    // Frame buffer storage; contents only matter while a frame is held.
    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_addr] <= rx_data;
    end

    // Registered read port.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) rd_data <= 8'h00;
        else           rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_modbus_frame_rx.sv
// ----------------------------------------------------------------------------
// tb_modbus_frame_rx
// Directed bench for modbus_frame_rx with shortened silent intervals
// (CLK_FREQ=16000 gives t1.5 = 12 and t3.5 = 28 clocks) and an 8-byte buffer.
// Each sent frame pushes its modelled outcome onto a scoreboard queue, which
// is popped and compared when the receiver reports (or fails to report).
// ----------------------------------------------------------------------------
module tb_modbus_frame_rx;

    localparam int T15     = 12;
    localparam int T35     = 28;
    localparam int LIMIT   = T35 + 20;
    localparam int K_NONE  = 0;
    localparam int K_VALID = 1;
    localparam int K_ERR   = 2;

    logic       clk_in;
    logic       rst_n_in;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_state;
    logic       frame_valid;
    logic       frame_ack;
    logic [3:0] frame_len;
    logic       frame_bcast;
    logic       frame_err;
    logic [2:0] err_type;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    typedef struct packed {
        logic [1:0]  kind;
        logic [2:0]  et;
        logic [3:0]  len;
        logic        bcast;
        logic [63:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] frame_q[$];
    logic [63:0] held_data;
    int checks   = 0;
    int failures = 0;

    modbus_frame_rx #(
        .CLK_FREQ   (16000),
        .BAUD_RATE  (115200),
        .SLAVE_ADDR (8'h01),
        .MAX_LEN    (8)
    ) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rx_state    (rx_state),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_len   (frame_len),
        .frame_bcast (frame_bcast),
        .frame_err   (frame_err),
        .err_type    (err_type),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Bit-serial CRC-16/Modbus reference over the whole of frame_q.
    function automatic logic [15:0] model_crc();
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (frame_q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frame_q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    task automatic add_crc();
        logic [15:0] c;
        c = model_crc();
        frame_q.push_back(c[7:0]);
        frame_q.push_back(c[15:8]);
    endtask

    // busy_cyc = 0 models a byte strobe arriving without a busy phase, so the
    // preceding idle time is still visible in the silence timer.
    task automatic send_byte(input logic [7:0] d, input int pre_idle, input int busy_cyc);
        repeat (pre_idle) tick();
        if (busy_cyc > 0) begin
            rx_state = 1'b1;
            repeat (busy_cyc) tick();
            rx_state = 1'b0;
        end
        rx_data = d;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input int gap_idx, input bit push);
        exp_t        e;
        int          n;
        int          lenm;
        bit          ovf;
        logic [15:0] c;
        logic [2:0]  err;
        n    = frame_q.size();
        ovf  = (n > 8);
        lenm = ovf ? 8 : n;
        c    = model_crc();
        err  = {(lenm < 4) || ovf, gap_idx > 0, c != 16'h0000};
        e    = '0;
        e.et = err;
        e.len = 4'(lenm);
        e.bcast = (frame_q[0] == 8'h00);
        for (int i = 0; i < lenm; i++) e.data[i*8 +: 8] = frame_q[i];
        if (err != 3'b000)                                e.kind = 2'(K_ERR);
        else if (frame_q[0] == 8'h01 || frame_q[0] == 8'h00) e.kind = 2'(K_VALID);
        else                                              e.kind = 2'(K_NONE);
        if (push) exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            if (i == gap_idx) send_byte(frame_q[i], T15 + 3, 0);
            else              send_byte(frame_q[i], 0, 5);
        end
    endtask

    task automatic readback(input logic [63:0] data, input int len, input string tag);
        for (int i = 0; i < len; i++) begin
            rd_addr = 3'(i);
            tick();
            check(tag, rd_data, data[i*8 +: 8]);
        end
    endtask

    task automatic ack_frame();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check("valid_fall", frame_valid, 1'b0);
        repeat (3) tick();
    endtask

    task automatic checkOutput(input bit check_lat);
        exp_t e;
        int   n;
        bit   seen;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e    = exp_q.pop_front();
        seen = 1'b0;
        n    = 0;
        while (!seen && n < LIMIT) begin
            tick();
            n++;
            if (frame_valid || frame_err) seen = 1'b1;
        end
        if (int'(e.kind) == K_NONE) begin
            check("no_event", seen, 1'b0);
        end else begin
            check("event_seen", seen, 1'b1);
            if (seen) begin
                if (check_lat) check("latency", n, T35 + 1);
                check("busy_done", busy, 1'b0);
                check("frame_valid", frame_valid, int'(e.kind) == K_VALID);
                check("frame_err", frame_err, int'(e.kind) == K_ERR);
                check("err_type", err_type, e.et);
                if (int'(e.kind) == K_VALID) begin
                    check("frame_len", frame_len, e.len);
                    check("frame_bcast", frame_bcast, e.bcast);
                    readback(e.data, int'(e.len), "rd_data");
                end else begin
                    tick();
                    check("err_pulse", frame_err, 1'b0);
                    check("err_no_valid", frame_valid, 1'b0);
                    check("err_type_hold", err_type, e.et);
                end
            end
        end
        repeat (3) tick();
    endtask

    task automatic applyStimulus(input int gap_idx);
        send_frame(gap_idx, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, frame_valid, 1'b0);
        check({tag, "_err"},   frame_err,   1'b0);
        check({tag, "_etype"}, err_type,    3'b000);
        check({tag, "_len"},   frame_len,   4'h0);
        check({tag, "_bcast"}, frame_bcast, 1'b0);
        check({tag, "_busy"},  busy,        1'b0);
        check({tag, "_rd"},    rd_data,     8'h00);
    endtask

    function automatic void load_good();
        frame_q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    endfunction

    initial begin
        int  pend_err;
        bit  pend_drop;
        rst_n_in  = 1'b0;
        rx_data   = 8'h00;
        rx_done   = 1'b0;
        rx_state  = 1'b0;
        frame_ack = 1'b0;
        rd_addr   = 3'd0;
        repeat (3) tick();
        check_reset_values("reset");
        rst_n_in = 1'b1;
        repeat (T35 + 10) tick();

        // Known-good read-holding-registers request, with end-of-frame timing.
        load_good();
        applyStimulus(-1);
        checkOutput(1'b1);
        ack_frame();

        // Corrupted CRC high byte.
        load_good();
        frame_q[7] = 8'h0B;
        applyStimulus(-1);
        checkOutput(1'b0);

        // Broadcast address with a model-generated CRC.
        frame_q = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        add_crc();
        applyStimulus(-1);
        checkOutput(1'b0);
        ack_frame();

        // Foreign station address is dropped silently; last good frame info holds.
        frame_q = '{8'h05, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        add_crc();
        applyStimulus(-1);
        checkOutput(1'b0);
        check("len_hold", frame_len, 4'd8);
        check("bcast_hold", frame_bcast, 1'b1);

        // Inter-character gap before the fourth byte.
        load_good();
        applyStimulus(3);
        checkOutput(1'b0);

        // Three-byte frame with a valid CRC: only the length error remains.
        frame_q = '{8'h01};
        add_crc();
        applyStimulus(-1);
        checkOutput(1'b0);

        // Nine bytes into an eight-byte buffer.
        load_good();
        frame_q.push_back(8'h55);
        applyStimulus(-1);
        checkOutput(1'b0);

        // Second frame while a good one is pending must leave it untouched.
        load_good();
        held_data = 64'h0A84_0100_0000_0301;
        applyStimulus(-1);
        checkOutput(1'b0);
        frame_q = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        add_crc();
        send_frame(-1, 1'b0);
        pend_err  = 0;
        pend_drop = 1'b0;
        repeat (T35 + 10) begin
            tick();
            if (frame_err)    pend_err++;
            if (!frame_valid) pend_drop = 1'b1;
        end
        check("pend_no_err", pend_err, 0);
        check("pend_valid_held", pend_drop, 1'b0);
        check("pend_len", frame_len, 4'd8);
        check("pend_bcast", frame_bcast, 1'b0);
        readback(held_data, 8, "pend_rd_data");
        ack_frame();

        // Reset in the middle of a frame, then bytes inside the t3.5 guard.
        load_good();
        for (int i = 0; i < 4; i++) send_byte(frame_q[i], 0, 5);
        check("busy_mid_frame", busy, 1'b1);
        rst_n_in = 1'b0;
        tick();
        check_reset_values("midreset");
        rst_n_in = 1'b1;
        repeat (5) tick();
        load_good();
        exp_q.push_back('0);
        send_frame(-1, 1'b0);
        checkOutput(1'b0);
        repeat (T35 + 10) tick();
        load_good();
        applyStimulus(-1);
        checkOutput(1'b0);
        ack_frame();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
